// File: rtl/rvv_backend_mulmac_lanes.sv
// Multi-lane MUL/MAC execution wrapper: in-order thermometer pop from the RS FIFO,
// per-lane stallable LAT-stage multiply pipeline, per-lane valid/ready to the ROB.
// Optional perf counters enabled by defining RVV_MULMAC_PERF_CNT_EN.
module rvv_backend_mulmac_lanes #(
  parameter int unsigned NUM_LANE = 2,
  parameter int unsigned LAT      = 3,
  parameter int unsigned OP_W     = 32,
  parameter int unsigned TAG_W    = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               trap_flush_rvv,
  input  logic [$clog2(NUM_LANE+1)-1:0]      rs2ex_fifo_cnt,
  input  logic [NUM_LANE*OP_W-1:0]           rs2ex_uop_a,
  input  logic [NUM_LANE*OP_W-1:0]           rs2ex_uop_b,
  input  logic [NUM_LANE-1:0]                rs2ex_uop_signed,
  input  logic [NUM_LANE*TAG_W-1:0]          rs2ex_uop_tag,
  output logic [NUM_LANE-1:0]                ex2rs_fifo_pop,
  output logic [NUM_LANE-1:0]                ex2rob_valid,
  output logic [NUM_LANE*2*OP_W-1:0]         ex2rob_result,
  output logic [NUM_LANE*TAG_W-1:0]          ex2rob_tag,
  input  logic [NUM_LANE-1:0]                rob2ex_ready
`ifdef RVV_MULMAC_PERF_CNT_EN
  ,
  output logic [31:0]                        perf_pop_cnt,
  output logic [31:0]                        perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_LANE + 1);
  localparam int unsigned RES_W = 2 * OP_W;

  logic [NUM_LANE-1:0] cand;
  logic [NUM_LANE-1:0] lane_rdy;
  logic [NUM_LANE-1:0] pop;
  logic                chain;

  // In-order pop: a slot may only pop if every older slot pops this cycle.
  always_comb begin
    cand  = '0;
    pop   = '0;
    chain = 1'b1;
    for (int i = 0; i < NUM_LANE; i++) begin
      cand[i] = (rs2ex_fifo_cnt > CNT_W'(i)) && !trap_flush_rvv && !rst;
      pop[i]  = cand[i] && lane_rdy[i] && chain;
      chain   = pop[i];
    end
  end

  assign ex2rs_fifo_pop = pop;

  for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
    logic [LAT-1:0]   vld_q;
    logic [RES_W-1:0] res_q [LAT];
    logic [TAG_W-1:0] tag_q [LAT];
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             sgn;
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [RES_W-1:0] prod;

    assign op_a  = rs2ex_uop_a[l*OP_W +: OP_W];
    assign op_b  = rs2ex_uop_b[l*OP_W +: OP_W];
    assign sgn   = rs2ex_uop_signed[l];
    // Extending both operands to the full product width makes one multiplier
    // exact for both signed and unsigned operation (mod 2^RES_W).
    assign a_ext = sgn ? {{OP_W{op_a[OP_W-1]}}, op_a} : {{OP_W{1'b0}}, op_a};
    assign b_ext = sgn ? {{OP_W{op_b[OP_W-1]}}, op_b} : {{OP_W{1'b0}}, op_b};
    assign prod  = a_ext * b_ext;

    assign lane_rdy[l] = !vld_q[LAT-1] || rob2ex_ready[l];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int k = 0; k < LAT; k++) begin
          res_q[k] <= '0;
          tag_q[k] <= '0;
        end
      end else begin
        if (trap_flush_rvv) begin
          vld_q <= '0;
        end else if (lane_rdy[l]) begin
          vld_q[0] <= pop[l];
          for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
        end
        // Data shifts with the valids; a stalled lane holds everything.
        if (lane_rdy[l]) begin
          res_q[0] <= prod;
          tag_q[0] <= rs2ex_uop_tag[l*TAG_W +: TAG_W];
          for (int k = 1; k < LAT; k++) begin
            res_q[k] <= res_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end
    end

    assign ex2rob_valid[l]                   = vld_q[LAT-1] && !trap_flush_rvv;
    assign ex2rob_result[l*RES_W +: RES_W]   = res_q[LAT-1];
    assign ex2rob_tag[l*TAG_W +: TAG_W]      = tag_q[LAT-1];
  end

`ifdef RVV_MULMAC_PERF_CNT_EN
  // Free-running counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pop_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_pop_cnt <= perf_pop_cnt + 32'($countones(pop));
      if (|(ex2rob_valid & ~rob2ex_ready)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvv_backend_mulmac_lanes.sv
// Scoreboard bench for rvv_backend_mulmac_lanes (NUM_LANE=2, LAT=3, OP_W=8):
// directed scenarios followed by randomized traffic against an item-level model.
module tb_rvv_backend_mulmac_lanes;
  localparam int NL  = 2;
  localparam int LAT = 3;
  localparam int OW  = 8;
  localparam int TW  = 6;
  localparam int RW  = 2 * OW;

  typedef struct packed {
    logic [RW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trap_flush_rvv = 1'b0;
  logic [1:0]        rs2ex_fifo_cnt = '0;
  logic [NL*OW-1:0]  rs2ex_uop_a = '0;
  logic [NL*OW-1:0]  rs2ex_uop_b = '0;
  logic [NL-1:0]     rs2ex_uop_signed = '0;
  logic [NL*TW-1:0]  rs2ex_uop_tag = '0;
  logic [NL-1:0]     ex2rs_fifo_pop;
  logic [NL-1:0]     ex2rob_valid;
  logic [NL*RW-1:0]  ex2rob_result;
  logic [NL*TW-1:0]  ex2rob_tag;
  logic [NL-1:0]     rob2ex_ready = '1;
`ifdef RVV_MULMAC_PERF_CNT_EN
  logic [31:0]       perf_pop_cnt;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       e_pop_cnt = '0;
  logic [31:0]       e_stall_cnt = '0;
`endif

  always #5 clk = ~clk;

  rvv_backend_mulmac_lanes #(.NUM_LANE(NL), .LAT(LAT), .OP_W(OW), .TAG_W(TW)) dut (
    .clk              (clk),
    .rst              (rst),
    .trap_flush_rvv   (trap_flush_rvv),
    .rs2ex_fifo_cnt   (rs2ex_fifo_cnt),
    .rs2ex_uop_a      (rs2ex_uop_a),
    .rs2ex_uop_b      (rs2ex_uop_b),
    .rs2ex_uop_signed (rs2ex_uop_signed),
    .rs2ex_uop_tag    (rs2ex_uop_tag),
    .ex2rs_fifo_pop   (ex2rs_fifo_pop),
    .ex2rob_valid     (ex2rob_valid),
    .ex2rob_result    (ex2rob_result),
    .ex2rob_tag       (ex2rob_tag),
    .rob2ex_ready     (rob2ex_ready)
`ifdef RVV_MULMAC_PERF_CNT_EN
    ,
    .perf_pop_cnt     (perf_pop_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Item-level model: per lane, the cycles-since-pop age of each in-flight uop,
  // and the expected (result, tag) sequence the ROB side must see.
  int   ages [NL][$];
  exp_t sb   [NL][$];

  bit          s_rst = 1'b1;
  bit          s_flush = 1'b0;
  int          s_cnt = 0;
  logic [OW-1:0] s_a [NL];
  logic [OW-1:0] s_b [NL];
  bit          s_sg [NL];
  logic [TW-1:0] s_tag [NL];
  logic [NL-1:0] s_rdy = '1;
  bit          prev_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  function automatic logic [RW-1:0] ref_mul(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                            input bit s);
    int sa;
    int sbv;
    int p;
    sa  = (s && a[OW-1]) ? int'(a) - (1 << OW) : int'(a);
    sbv = (s && b[OW-1]) ? int'(b) - (1 << OW) : int'(b);
    p   = sa * sbv;
    return RW'(p);
  endfunction

  task automatic set_slot(input int l, input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input bit sg, input logic [TW-1:0] tag);
    s_a[l] = a; s_b[l] = b; s_sg[l] = sg; s_tag[l] = tag;
  endtask

  task automatic rand_slots();
    for (int l = 0; l < NL; l++)
      set_slot(l, OW'($urandom), OW'($urandom), bit'($urandom % 2), TW'($urandom));
  endtask

  // One clock cycle: drive staged inputs, predict, compare, then advance the model.
  task automatic step();
    logic [NL-1:0] head, lrdy, epop, evld;
    bit chain;
    @(posedge clk); #1;
    rst            = s_rst;
    trap_flush_rvv = s_flush;
    rs2ex_fifo_cnt = 2'(s_cnt);
    rob2ex_ready   = s_rdy;
    for (int l = 0; l < NL; l++) begin
      rs2ex_uop_a[l*OW +: OW]   = s_a[l];
      rs2ex_uop_b[l*OW +: OW]   = s_b[l];
      rs2ex_uop_signed[l]       = s_sg[l];
      rs2ex_uop_tag[l*TW +: TW] = s_tag[l];
    end
    chain = 1'b1;
    for (int l = 0; l < NL; l++) begin
      head[l] = (ages[l].size() > 0) && (ages[l][0] == LAT - 1);
      lrdy[l] = !head[l] || s_rdy[l];
      epop[l] = (l < s_cnt) && !s_flush && !s_rst && lrdy[l] && chain;
      chain   = epop[l];
      evld[l] = head[l] && !s_flush;
    end
    @(negedge clk);
    chk("pop", 32'(ex2rs_fifo_pop), 32'(epop));
    chk("valid", 32'(ex2rob_valid), 32'(evld));
    if (prev_rst) begin
      chk("rst_result", ex2rob_result, 32'h0);
      chk("rst_tag", 32'(ex2rob_tag), 32'h0);
    end
    for (int l = 0; l < NL; l++) begin
      if (evld[l] && !s_rdy[l]) begin
        chk($sformatf("hold_res_l%0d", l), 32'(ex2rob_result[l*RW +: RW]), 32'(sb[l][0].res));
        chk($sformatf("hold_tag_l%0d", l), 32'(ex2rob_tag[l*TW +: TW]), 32'(sb[l][0].tag));
      end
    end
`ifdef RVV_MULMAC_PERF_CNT_EN
    chk("perf_pop", perf_pop_cnt, e_pop_cnt);
    chk("perf_stall", perf_stall_cnt, e_stall_cnt);
    if (s_rst) begin
      e_pop_cnt = '0; e_stall_cnt = '0;
    end else begin
      e_pop_cnt = e_pop_cnt + 32'($countones(epop));
      if (|(evld & ~s_rdy)) e_stall_cnt = e_stall_cnt + 32'd1;
    end
`endif
    if (s_rst || s_flush) begin
      for (int l = 0; l < NL; l++) begin
        ages[l].delete();
        sb[l].delete();
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (lrdy[l]) begin
          if (head[l]) void'(ages[l].pop_front());
          for (int k = 0; k < ages[l].size(); k++) ages[l][k] = ages[l][k] + 1;
          if (epop[l]) begin
            ages[l].push_back(0);
            sb[l].push_back('{res: ref_mul(s_a[l], s_b[l], s_sg[l]), tag: s_tag[l]});
          end
        end
      end
    end
    prev_rst = s_rst;
  endtask

  task automatic idle(input int n);
    s_cnt = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every accepted ROB result must be the oldest expected one for its lane.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !trap_flush_rvv) begin
        for (int l = 0; l < NL; l++) begin
          if (ex2rob_valid[l] && rob2ex_ready[l]) begin
            if (sb[l].size() == 0) begin
              n_chk++;
              $display("FAIL out_l%0d: unexpected result 0x%0h tag 0x%0h, want none", l,
                       ex2rob_result[l*RW +: RW], ex2rob_tag[l*TW +: TW]);
            end else begin
              e = sb[l].pop_front();
              chk($sformatf("out_res_l%0d", l), 32'(ex2rob_result[l*RW +: RW]), 32'(e.res));
              chk($sformatf("out_tag_l%0d", l), 32'(ex2rob_tag[l*TW +: TW]), 32'(e.tag));
            end
          end
        end
      end
    end
  end

  initial begin
    for (int l = 0; l < NL; l++) set_slot(l, '0, '0, 1'b0, '0);
    // reset
    s_rst = 1'b1; s_rdy = 2'b11;
    idle(2);
    s_rst = 1'b0;
    idle(1);

    // basic unsigned/signed pair, 3-cycle latency
    set_slot(0, 8'h03, 8'h05, 1'b0, 6'h11);
    set_slot(1, 8'hFD, 8'h05, 1'b1, 6'h2A);
    s_cnt = 2; step();
    chk("t1_pop", 32'(ex2rs_fifo_pop), 32'h3);
    idle(3);
    chk("t1_valid", 32'(ex2rob_valid), 32'h3);
    chk("t1_res0", 32'(ex2rob_result[15:0]), 32'h000F);
    chk("t1_res1", 32'(ex2rob_result[31:16]), 32'hFFF1);
    chk("t1_tag0", 32'(ex2rob_tag[5:0]), 32'h11);
    chk("t1_tag1", 32'(ex2rob_tag[11:6]), 32'h2A);
    idle(1);

    // stalled lane 0 blocks lane 1 pop
    rand_slots();
    s_cnt = 1; step();
    idle(2);
    s_cnt = 2; s_rdy = 2'b10; rand_slots(); step();
    chk("thermo_block", 32'(ex2rs_fifo_pop), 32'h0);
    s_rdy = 2'b11; step();
    chk("thermo_release", 32'(ex2rs_fifo_pop), 32'h3);
    idle(4);

    // backpressure with a full lane-0 pipeline
    for (int i = 0; i < 3; i++) begin
      rand_slots(); s_cnt = 1; step();
    end
    s_rdy = 2'b10; s_cnt = 2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_no_pop0", 32'(ex2rs_fifo_pop[0]), 32'h0);
    end
    s_rdy = 2'b11;
    idle(5);

    // flush with three uops in flight
    rand_slots(); s_cnt = 2; step();
    rand_slots(); s_cnt = 1; step();
    s_flush = 1'b1; s_cnt = 2; step();
    chk("flush_pop", 32'(ex2rs_fifo_pop), 32'h0);
    chk("flush_valid", 32'(ex2rob_valid), 32'h0);
    s_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("post_flush_valid", 32'(ex2rob_valid), 32'h0);
    end

    // boundaries: single-entry FIFO, extreme operands
    rand_slots(); s_cnt = 1; step();
    chk("cnt1_pop", 32'(ex2rs_fifo_pop), 32'h1);
    idle(4);
    set_slot(0, 8'h80, 8'h80, 1'b1, 6'h05);
    set_slot(1, 8'hFF, 8'hFF, 1'b0, 6'h3F);
    s_cnt = 2; step();
    idle(3);
    chk("bnd_signed", 32'(ex2rob_result[15:0]), 32'h4000);
    chk("bnd_unsigned", 32'(ex2rob_result[31:16]), 32'hFE01);
    idle(1);

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      rand_slots(); s_cnt = 2; step();
    end
    s_rst = 1'b1; step();
    s_rst = 1'b0; idle(1);
    chk("rst_mid_valid", 32'(ex2rob_valid), 32'h0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rand_slots();
      s_rst   = ($urandom % 90) == 0;
      s_flush = ($urandom % 25) == 0;
      s_cnt   = int'($urandom % 3);
      for (int l = 0; l < NL; l++) s_rdy[l] = ($urandom % 10) < 7;
      step();
    end
    s_rst = 1'b0; s_flush = 1'b0; s_rdy = 2'b11;
    idle(6);
    for (int l = 0; l < NL; l++) chk($sformatf("drained_l%0d", l), 32'(sb[l].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
